// File: rtl/accum_max_sequencer.sv
// accum_max_sequencer: valid-qualified window sequencer driving load/result strobes of a max-pool accumulator.
// Optional sticky overrun detection is compiled in when ACCUM_MAX_SEQ_OVERRUN_EN is defined.
module accum_max_sequencer #(
  parameter int DELAY_W  = 7,
  parameter int STRIDE_W = 16,
  parameter int COUNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                run_i,
  input  logic                running_i,
  input  logic                in_valid_i,
  input  logic [DELAY_W-1:0]  delay0_i,
  input  logic [STRIDE_W-1:0] windowMinusOne_i,
  input  logic [COUNT_W-1:0]  numWindowsMinusOne_i,
  output logic                accumStart_o,
  output logic                resultValid_o,
  output logic [COUNT_W-1:0]  windowIndex_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                overrun_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DELAY_W-1:0]  delayCnt_q, delayCnt_d;
  logic [STRIDE_W-1:0] winLim_q, winLim_d;
  logic [STRIDE_W-1:0] elemCnt_q, elemCnt_d;
  logic [COUNT_W-1:0]  numLim_q, numLim_d;
  logic [COUNT_W-1:0]  windowCnt_q, windowCnt_d;
  logic [COUNT_W-1:0]  windowIndex_q, windowIndex_d;
  logic                resultValid_q, resultValid_d;

  logic consume;
  logic lastElem;
  logic lastWindow;

  assign consume    = running_i && in_valid_i;
  assign lastElem   = (elemCnt_q == winLim_q);
  assign lastWindow = (windowCnt_q == numLim_q);

  always_comb begin
    state_d       = state_q;
    delayCnt_d    = delayCnt_q;
    winLim_d      = winLim_q;
    elemCnt_d     = elemCnt_q;
    numLim_d      = numLim_q;
    windowCnt_d   = windowCnt_q;
    windowIndex_d = windowIndex_q;
    resultValid_d = 1'b0;
    accumStart_o  = 1'b0;

    if ((state_q == ACCUM) && (elemCnt_q == '0) && consume) begin
      accumStart_o = 1'b1;
    end

    // run restarts from any state regardless of running; a coincident window completion is dropped
    if (run_i) begin
      delayCnt_d  = delay0_i;
      winLim_d    = windowMinusOne_i;
      numLim_d    = numWindowsMinusOne_i;
      elemCnt_d   = '0;
      windowCnt_d = '0;
      state_d     = (delay0_i != '0) ? DELAY : ACCUM;
    end else if (running_i) begin
      unique case (state_q)
        DELAY: begin
          if (delayCnt_q == DELAY_W'(1)) begin
            state_d = ACCUM;
          end else begin
            delayCnt_d = delayCnt_q - DELAY_W'(1);
          end
        end
        ACCUM: begin
          if (in_valid_i) begin
            if (lastElem) begin
              elemCnt_d     = '0;
              resultValid_d = 1'b1;
              windowIndex_d = windowCnt_q;
              if (lastWindow) begin
                state_d = DONE;
              end else begin
                windowCnt_d = windowCnt_q + COUNT_W'(1);
              end
            end else begin
              elemCnt_d = elemCnt_q + STRIDE_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      delayCnt_q    <= '0;
      winLim_q      <= '0;
      elemCnt_q     <= '0;
      numLim_q      <= '0;
      windowCnt_q   <= '0;
      windowIndex_q <= '0;
      resultValid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      delayCnt_q    <= delayCnt_d;
      winLim_q      <= winLim_d;
      elemCnt_q     <= elemCnt_d;
      numLim_q      <= numLim_d;
      windowCnt_q   <= windowCnt_d;
      windowIndex_q <= windowIndex_d;
      resultValid_q <= resultValid_d;
    end
  end

  assign resultValid_o = resultValid_q;
  assign windowIndex_o = windowIndex_q;
  assign busy_o        = (state_q == DELAY) || (state_q == ACCUM);
  assign done_o        = (state_q == DONE);

`ifdef ACCUM_MAX_SEQ_OVERRUN_EN
  logic overrun_q, overrun_d;
  logic armed_q, armed_d;

  // IDLE only counts as an overrun once a sequence has been started since reset
  always_comb begin
    armed_d   = armed_q || run_i;
    overrun_d = overrun_q;
    if (run_i) begin
      overrun_d = 1'b0;
    end else if (consume && ((state_q == DONE) || ((state_q == IDLE) && armed_q))) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      armed_q   <= armed_d;
    end
  end

  assign overrun_o = overrun_q;
`else
  assign overrun_o = 1'b0;
`endif

endmodule
